// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type and prescale helpers for the UART RX sequencer
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CHECK
  } rx_state_t;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  typedef enum logic [1:0] {
    PS_8,
    PS_16,
    PS_32
  } presc_code_t;

  // Anything that is not a supported ratio falls back to x8.
  function automatic presc_code_t presc_decode(input logic [5:0] prescale);
    case (prescale)
      PRESC_8:  return PS_8;
      PRESC_16: return PS_16;
      PRESC_32: return PS_32;
      default:  return PS_8;
    endcase
  endfunction

  function automatic logic [5:0] presc_last(input presc_code_t code);
    case (code)
      PS_16:   return 6'd15;
      PS_32:   return 6'd31;
      default: return 6'd7;
    endcase
  endfunction

  // Vote spans P/2-1..P/2+1, so the voted bit is usable at P/2+2.
  function automatic logic [5:0] presc_samp(input presc_code_t code);
    case (code)
      PS_16:   return 6'd10;
      PS_32:   return 6'd18;
      default: return 6'd6;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversample edge counter and bit index counter
module uart_rx_edge_bit_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [5:0] edge_last,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic [5:0] edge_nxt
);

  logic [3:0] bit_nxt;

  // Next values are exported so the controller can register its enables against them.
  always_comb begin
    edge_nxt = 6'd0;
    bit_nxt  = 4'd0;
    if (en && !clr) begin
      if (edge_cnt == edge_last) begin
        edge_nxt = 6'd0;
        bit_nxt  = bit_cnt + 4'd1;
      end else begin
        edge_nxt = edge_cnt + 6'd1;
        bit_nxt  = bit_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else begin
      edge_cnt <= edge_nxt;
      bit_cnt  <= bit_nxt;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX frame sequencer: start detect, checker enables, frame accept
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic [5:0] prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       samp_done,
  output logic       data_valid
);

  localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH);

  rx_state_t   state;
  rx_state_t   state_nxt;
  presc_code_t presc_code;
  presc_code_t presc_code_nxt;
  logic [5:0]  edge_last;
  logic [5:0]  edge_nxt;
  logic [5:0]  samp_pt;
  logic        at_last;
  logic        cnt_en;
  logic        cnt_clr;

  assign edge_last = presc_last(presc_code);
  assign at_last   = (edge_cnt == edge_last);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!rx_in) state_nxt = ST_START;
      ST_START:  if (at_last) state_nxt = strt_glitch ? ST_IDLE : ST_DATA;
      ST_DATA:   if (at_last && bit_cnt == BIT_LAST) state_nxt = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (at_last) state_nxt = ST_STOP;
      // Leave one tick early so the CHECK cycle still lies inside the stop bit.
      ST_STOP:   if (edge_cnt == edge_last - 6'd1) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = rx_in ? ST_IDLE : ST_START;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Every entry into START restarts the counters and captures a fresh ratio.
  assign cnt_en         = (state_nxt != ST_IDLE);
  assign cnt_clr        = (state_nxt == ST_START) && (state != ST_START);
  assign presc_code_nxt = cnt_clr ? presc_decode(prescale) : presc_code;
  assign samp_pt        = presc_samp(presc_code_nxt);

  uart_rx_edge_bit_cnt u_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .edge_last (edge_last),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .edge_nxt  (edge_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      presc_code  <= PS_8;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      samp_done   <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc_code  <= presc_code_nxt;
      dat_samp_en <= state_nxt inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
      deser_en    <= (state_nxt == ST_DATA) && (edge_nxt == samp_pt);
      strt_chk_en <= (state_nxt == ST_START);
      par_chk_en  <= (state_nxt == ST_PARITY);
      stp_chk_en  <= (state_nxt == ST_STOP);
      samp_done   <= (state_nxt != ST_IDLE) && (edge_nxt == samp_pt);
      data_valid  <= (state_nxt == ST_CHECK) && !stp_err && !(par_en && par_err);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int DW       = 8;
  localparam int K_OK     = 0;
  localparam int K_GLITCH = 1;
  localparam int K_PERR   = 2;
  localparam int K_SERR   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, samp_done, data_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur_s = 6;
  int dv_q[$];
  int ds_q[$];

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .samp_done   (samp_done),
    .data_valid  (data_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int outs_vec();
    return int'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                 par_chk_en, stp_chk_en, samp_done, data_valid});
  endfunction

  function automatic int ratio_of(input logic [5:0] code);
    if (code == 6'd16) return 16;
    if (code == 6'd32) return 32;
    return 8;
  endfunction

  always @(negedge clk) begin
    while (dv_q.size() > 0 && dv_q[0] < cyc) begin
      check("dv_missing", cyc, dv_q[0]);
      void'(dv_q.pop_front());
    end
    while (ds_q.size() > 0 && ds_q[0] < cyc) begin
      check("deser_missing", cyc, ds_q[0]);
      void'(ds_q.pop_front());
    end
    if (data_valid) begin
      if (dv_q.size() == 0) check("dv_unexpected", cyc, -1);
      else check("dv_time", cyc, dv_q.pop_front());
    end
    if (deser_en) begin
      if (ds_q.size() == 0) check("deser_unexpected", cyc, -1);
      else check("deser_time", cyc, ds_q.pop_front());
      check("deser_with_samp_done", int'(samp_done), 1);
    end
    if (samp_done) check("samp_done_edge", int'(edge_cnt), cur_s);
    if (strt_chk_en) check("strt_chk_bit", int'(bit_cnt), 0);
    if (par_chk_en) check("par_chk_bit", int'(bit_cnt), DW + 1);
  end

  task automatic send_frame(input logic [5:0] pc, input bit pe, input logic [7:0] d,
                            input int kind, input int gap, input int abort_k);
    int p, s, nb, n, b, l, glen;
    bit noise;
    p     = ratio_of(pc);
    s     = p / 2 + 2;
    nb    = DW + 2 + int'(pe);
    glen  = p / 4 + 2;
    n     = (kind == K_GLITCH) ? p + 1 : nb * p;
    noise = (kind == K_OK && !pe) ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int g = 0; g < gap; g++) begin
      rx_in = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      @(posedge clk); #1;
    end
    l     = cyc;
    cur_s = s;
    if (kind != K_GLITCH)
      for (int i = 1; i <= DW; i++) ds_q.push_back(l + i * p + s + 1);
    if (kind == K_OK) dv_q.push_back(l + nb * p);
    for (int k = 0; k < n; k++) begin
      if (k == abort_k) begin
        check("samp_en_before_rst", int'(dat_samp_en), 1);
        check("bit_before_rst", int'(bit_cnt), 4);
        rst = 1'b0;
        #1;
        check("rst_async_outs", outs_vec(), 0);
        dv_q.delete();
        ds_q.delete();
        rx_in = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      prescale = (k == 0) ? pc : 6'($urandom_range(0, 63));
      par_en   = pe;
      b        = k / p;
      if (kind == K_GLITCH) rx_in = (k >= glen);
      else if (b == 0) rx_in = 1'b0;
      else if (b <= DW) rx_in = d[b-1];
      else if (pe && b == DW + 1) rx_in = ^d;
      else rx_in = (kind != K_SERR);
      strt_glitch = (kind == K_GLITCH) && (k >= s);
      par_err     = (kind == K_PERR) ? (k >= (DW + 1) * p + s) : noise;
      stp_err     = (kind == K_SERR) && (k >= (nb - 1) * p + s);
      @(posedge clk); #1;
    end
    if (kind == K_GLITCH) begin
      check("glitch_edge_cnt", int'(edge_cnt), 0);
      check("glitch_bit_cnt", int'(bit_cnt), 0);
      check("glitch_samp_en", int'(dat_samp_en), 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [5:0] pc;
    bit pe, force0;
    int kind, gap;
    @(posedge clk); @(posedge clk); #1;
    check("reset_outs", outs_vec(), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    send_frame(6'd8, 1'b1, 8'hA5, K_OK, 3, -1);
    send_frame(6'd16, 1'b0, 8'h3C, K_OK, 4, -1);
    send_frame(6'd16, 1'b0, 8'hC3, K_OK, 0, -1);
    send_frame(6'd32, 1'b0, 8'($urandom), K_GLITCH, 5, -1);
    send_frame(6'd32, 1'b0, 8'($urandom), K_OK, 0, -1);
    send_frame(6'd8, 1'b1, 8'($urandom), K_PERR, 2, -1);
    send_frame(6'd8, 1'b1, 8'($urandom), K_OK, 2, -1);
    send_frame(6'd16, 1'b0, 8'($urandom), K_SERR, 3, -1);
    send_frame(6'd16, 1'b0, 8'($urandom), K_OK, 0, -1);
    send_frame(6'd16, 1'b1, 8'($urandom), K_OK, 2, 4 * 16 + 4);
    send_frame(6'd16, 1'b1, 8'($urandom), K_OK, 3, -1);

    pc = 6'd16;
    pe = 1'b1;
    force0 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      gap = force0 ? 0 : int'($urandom_range(0, 4));
      if (gap != 0) begin
        case ($urandom_range(0, 3))
          0:       pc = 6'd8;
          1:       pc = 6'd16;
          2:       pc = 6'd32;
          default: pc = 6'($urandom_range(0, 63));
        endcase
        pe = 1'($urandom_range(0, 1));
      end
      case ($urandom_range(0, 5))
        3:       kind = K_GLITCH;
        4:       kind = pe ? K_PERR : K_OK;
        5:       kind = K_SERR;
        default: kind = K_OK;
      endcase
      force0 = (kind == K_SERR);
      send_frame(pc, pe, 8'($urandom), kind, gap, -1);
    end

    rx_in = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("dv_queue_drained", dv_q.size(), 0);
    check("deser_queue_drained", ds_q.size(), 0);
    check("idle_outs", outs_vec(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART RX path. It detects the start bit, runs the oversampling edge and bit counters, and enables the data sampler, deserializer and the start, parity and stop checkers in frame order. It evaluates checker results at the end of the frame and issues a one-cycle `data_valid`. It sits between the `rx_in` pin synchroniser and the RX datapath blocks, all in the UART RX clock domain.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `clk` in 1: UART RX oversampling clock.
- `rst` in 1: asynchronous, active-low reset.
- `rx_in` in 1: synchronised serial line; idle high.
- `par_en` in 1: parity bit present in frame.
- `prescale` in 6: oversampling ratio; legal values 8, 16, 32.
- `strt_glitch` in 1: start checker result, valid from the sampling point of bit 0.
- `par_err` in 1: parity checker result (sticky until `bit_cnt`==0).
- `stp_err` in 1: stop checker result.
- `edge_cnt` out 6: oversample tick within the current bit, 0..P-1.
- `bit_cnt` out 4: bit index. 0 = start, 1..DATA_WIDTH = data, then parity if `par_en`, then stop.
- `dat_samp_en` out 1: data sampler enable (majority vote).
- `deser_en` out 1: deserializer shift strobe.
- `strt_chk_en` out 1: start checker enable.
- `par_chk_en` out 1: parity checker enable.
- `stp_chk_en` out 1: stop checker enable.
- `samp_done` out 1: one-cycle pulse when `sampled_bit` is valid; this is the checkers' `done`.
- `data_valid` out 1: one-cycle pulse when the frame is accepted.

## Operation
- P = `prescale`, latched on the IDLE→START transition. Any value other than 16 or 32 is treated as 8.
- Sample point S = P/2 + 2. The majority vote covers edges P/2-1, P/2 and P/2+1, so the result is ready at S.
- Counters:
  - Enabled in every state except IDLE; cleared to 0 whenever disabled.
  - `edge_cnt` counts 0..P-1 and wraps to 0.
  - `bit_cnt` increments on each wrap.
- States: IDLE, START, DATA, PARITY, STOP, CHECK.
- IDLE: all enables 0. If `rx_in`==0, go to START; the counters start at 0 on the next cycle.
- START: `strt_chk_en`=1, `dat_samp_en`=1. At `edge_cnt`==P-1:
  - `strt_glitch`=1 → IDLE.
  - Otherwise → DATA.
- DATA: `dat_samp_en`=1. `deser_en`=1 for exactly one cycle per bit, at `edge_cnt`==S. At `edge_cnt`==P-1 with `bit_cnt`==DATA_WIDTH:
  - `par_en`=1 → PARITY.
  - `par_en`=0 → STOP.
- PARITY: `par_chk_en`=1, `dat_samp_en`=1. At `edge_cnt`==P-1 → STOP.
- STOP: `stp_chk_en`=1, `dat_samp_en`=1. At `edge_cnt`==P-2 → CHECK, so the frame ends inside the stop bit.
- CHECK: lasts one cycle.
  - `data_valid`=1 iff `par_err`==0 and `stp_err`==0 (`par_err` is ignored when `par_en`=0).
  - Next state: START if `rx_in`==0 (back-to-back frame, counters cleared), else IDLE.
- `samp_done`=1 when `edge_cnt`==S in any non-IDLE state.
- A failed frame produces no `data_valid`. No other error output exists; the checker flags remain visible to the system.
- `par_en` must be stable from START until CHECK. A change mid-frame gives undefined framing.

## Timing
- All outputs reset to 0; state resets to IDLE. Reset mid-frame aborts the frame immediately with no `data_valid`.
- Enables are registered outputs, decoded from next state and next counter values, so they align with the counter values shown.
- Frame length from the first low `rx_in` cycle to `data_valid`: (DATA_WIDTH + 1 + `par_en`)·P + P - 1 cycles, plus 1 cycle of IDLE detection.
- Glitch abort: return to IDLE P cycles after START entry. A new falling edge is accepted the cycle after.
- Continuous frames: zero idle cycles are required between a stop bit and the next start bit.

## Structure
- Shared package `uart_rx_pkg`:
  - state enum.
  - `PRESC_8/16/32` constants.
  - helper functions for S and P-1 from the latched prescale code.
- Sub-module `uart_rx_edge_bit_cnt`: `edge_cnt`/`bit_cnt` with enable, synchronous clear and wrap at P-1.
- `uart_rx_ctrl` holds the FSM, the prescale latch and output decode.

## Test plan
- P=8, `par_en`=1, frame 0xA5 with correct parity → `deser_en` pulses 8 times at `edge_cnt`==6; `data_valid`=1 at cycle 88 after start detection.
- P=16, `par_en`=0, two frames 0x3C and 0xC3 back-to-back with no idle gap → two `data_valid` pulses 160 cycles apart.
- P=32, start bit low for only 10 cycles, so `strt_glitch`=1 → return to IDLE at `edge_cnt`==31, no `data_valid`, counters 0.
- P=8, `par_en`=1, `par_err` forced 1 at the parity sampling point → STOP and CHECK are traversed, `data_valid` stays 0, next frame is accepted normally.
- P=16, `stp_err`=1 (stop bit sampled low) → no `data_valid`. The line stays low, so CHECK→START is taken.
- `rst` asserted at `bit_cnt`==4 of a frame → all outputs 0 asynchronously. After release, a new clean frame yields `data_valid`.
